// File: rtl/custom_axi_ip_sched.sv
// Round-robin job scheduler sharing one custom_axi_ip increment engine among NUM_REQ requesters.
// Tracks the engine status sequence, returns tagged results, and flags engine ERROR or watchdog timeout.
module custom_axi_ip_sched #(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*16-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic [15:0]             eng_din_o,
    output logic                    eng_enable_o,
    input  logic [31:0]             eng_dout_i,
    input  logic [1:0]              eng_status_i,
    output logic                    busy_o,
    output logic [7:0]              err_cnt_o
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] ENG_IDLE  = 2'd0;
    localparam logic [1:0] ENG_DONE  = 2'd2;
    localparam logic [1:0] ENG_ERROR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_RESULT,
        S_RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [15:0]       op_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        err_cnt_q;

    logic [ID_W-1:0]   winner;
    logic              found;
    logic              tmo_hit;
    logic              done_ok;
    logic              done_err;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[rr_idx(rr_ptr_q, i)]) begin
                winner = rr_idx(rr_ptr_q, i);
                found  = 1'b1;
            end
        end
    end

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d      = state_q;
        eng_enable_o = 1'b0;
        done_ok      = 1'b0;
        done_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                eng_enable_o = 1'b1;
                state_d      = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (eng_status_i == ENG_ERROR || tmo_hit) done_err = 1'b1;
                else if (eng_status_i == ENG_DONE)        state_d  = S_WAIT_RESULT;
            end
            S_WAIT_RESULT: begin
                if (tmo_hit)                        done_err = 1'b1;
                else if (eng_status_i == ENG_IDLE)  done_ok  = 1'b1;
            end
            S_RESPOND: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (done_ok || done_err) state_d = S_RESPOND;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            op_q      <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && found) begin
                op_q     <= req_data_i[16*winner +: 16];
                id_q     <= winner;
                rr_ptr_q <= rr_idx(winner, 1);
            end
            if (state_q == S_ISSUE) begin
                tmo_q <= '0;
            end else if (state_q == S_WAIT_DONE || state_q == S_WAIT_RESULT) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (done_err) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end else if (done_ok) begin
                data_q <= eng_dout_i;
                err_q  <= 1'b0;
            end
            if (state_q == S_RESPOND && rsp_ready_i && err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Grant is forced low during reset so every output reads zero while rst_ni is asserted.
    assign req_ready_o = (rst_ni && state_q == S_IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_valid_o = (state_q == S_RESPOND);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign eng_din_o   = op_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_custom_axi_ip_sched.sv
// Self-checking bench for custom_axi_ip_sched: stub engine, job-timeline reference model, directed tests.
module tb_custom_axi_ip_sched;
    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int ID_W        = $clog2(NUM_REQ);

    logic                   clk_i       = 1'b0;
    logic                   rst_ni      = 1'b0;
    logic [NUM_REQ-1:0]     req_valid_i = '0;
    logic [NUM_REQ*16-1:0]  req_data_i  = '0;
    logic [NUM_REQ-1:0]     req_ready_o;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b1;
    logic [ID_W-1:0]        rsp_id_o;
    logic [31:0]            rsp_data_o;
    logic                   rsp_err_o;
    logic [15:0]            eng_din_o;
    logic                   eng_enable_o;
    logic [31:0]            eng_dout_i;
    logic [1:0]             eng_status_i;
    logic                   busy_o;
    logic [7:0]             err_cnt_o;

    custom_axi_ip_sched #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .eng_din_o    (eng_din_o),
        .eng_enable_o (eng_enable_o),
        .eng_dout_i   (eng_dout_i),
        .eng_status_i (eng_status_i),
        .busy_o       (busy_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Stub engine: 0 = nominal (BUSY,BUSY,DONE,IDLE), 1 = ERROR after enable, 2 = stuck BUSY.
    int          eng_mode = 0;
    int          eng_cnt  = 0;
    logic [15:0] eng_res  = '0;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eng_cnt <= 0;
            eng_res <= '0;
        end else if (eng_enable_o) begin
            eng_cnt <= 1;
            eng_res <= eng_din_o + 16'd1;
        end else if (eng_mode == 0 && eng_cnt != 0) begin
            eng_cnt <= (eng_cnt == 3) ? 0 : eng_cnt + 1;
        end
    end

    assign eng_dout_i   = {16'h0000, eng_res};
    assign eng_status_i = (eng_cnt == 0)  ? 2'd0 :
                          (eng_mode == 1) ? 2'd3 :
                          (eng_mode == 2) ? 2'd1 :
                          (eng_cnt == 3)  ? 2'd2 : 2'd1;

    // Reference model: a job accepted at cycle a responds at a+L (L = 6 nominal, 3 error, 2+TIMEOUT_CYC stuck).
    bit          m_idle   = 1'b1;
    int          m_ptr    = 0;
    int          m_id     = 0;
    logic [15:0] m_op     = '0;
    int          m_cd     = 0;
    bit          m_pend   = 1'b0;
    logic [31:0] m_data   = '0;
    bit          m_err    = 1'b0;
    bit          m_en     = 1'b0;
    int          m_errcnt = 0;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin : model_proc
        int w;
        if (!rst_ni) begin
            m_idle   = 1'b1;
            m_ptr    = 0;
            m_pend   = 1'b0;
            m_en     = 1'b0;
            m_op     = '0;
            m_cd     = 0;
            m_errcnt = 0;
        end else begin
            m_en = 1'b0;
            if (m_idle) begin
                w = pick(req_valid_i, m_ptr);
                if (w >= 0) begin
                    m_id   = w;
                    m_op   = req_data_i[16*w +: 16];
                    m_ptr  = (w + 1) % NUM_REQ;
                    m_idle = 1'b0;
                    m_en   = 1'b1;
                    if (eng_mode == 0) begin
                        m_data = {16'h0000, m_op + 16'd1};
                        m_err  = 1'b0;
                        m_cd   = 5;
                    end else begin
                        m_data = '0;
                        m_err  = 1'b1;
                        m_cd   = (eng_mode == 1) ? 2 : TIMEOUT_CYC + 1;
                    end
                end
            end else if (m_pend) begin
                if (rsp_ready_i) begin
                    m_pend = 1'b0;
                    m_idle = 1'b1;
                    if (m_err && m_errcnt < 255) m_errcnt++;
                end
            end else begin
                m_cd--;
                if (m_cd == 0) m_pend = 1'b1;
            end
        end
    end

    // Observation logs used by the directed literal checks.
    int          grant_log[$];
    logic [31:0] rsp_data_log[$];
    int          rsp_id_log[$];
    bit          rsp_err_log[$];
    int          en_count = 0;
    logic [15:0] en_din   = '0;
    int          accept_cyc = 0;
    int          rsp_cyc    = 0;
    int          hs_cyc     = 0;
    bit          prev_rsp_valid = 1'b0;

    always @(negedge clk_i) begin : compare_proc
        logic [NUM_REQ-1:0] exp_rdy;
        int w;
        exp_rdy = '0;
        if (rst_ni && m_idle) begin
            w = pick(req_valid_i, m_ptr);
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        checkOutput("req_ready",  32'(req_ready_o),  32'(exp_rdy));
        checkOutput("eng_enable", 32'(eng_enable_o), 32'(m_en));
        checkOutput("busy",       32'(busy_o),       32'(!m_idle));
        checkOutput("rsp_valid",  32'(rsp_valid_o),  32'(m_pend));
        checkOutput("err_cnt",    32'(err_cnt_o),    32'(m_errcnt));
        checkOutput("eng_din",    32'(eng_din_o),    32'(m_op));
        if (m_pend) begin
            checkOutput("rsp_id",   32'(rsp_id_o),  32'(m_id));
            checkOutput("rsp_data", rsp_data_o,     m_data);
            checkOutput("rsp_err",  32'(rsp_err_o), 32'(m_err));
        end
        if (rst_ni) begin
            if (eng_enable_o) begin
                en_count++;
                en_din = eng_din_o;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    grant_log.push_back(k);
                    accept_cyc = cyc;
                end
            end
            if (rsp_valid_o && !prev_rsp_valid) rsp_cyc = cyc;
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_data_log.push_back(rsp_data_o);
                rsp_id_log.push_back(int'(rsp_id_o));
                rsp_err_log.push_back(rsp_err_o);
                hs_cyc = cyc;
            end
        end
        prev_rsp_valid = rsp_valid_o;
    end

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*16-1:0] data, input logic ready);
        @(posedge clk_i);
        #1;
        req_valid_i = valid;
        req_data_i  = data;
        rsp_ready_i = ready;
    endtask

    task automatic pulseReq(input int k, input logic [15:0] d, input logic ready);
        logic [NUM_REQ*16-1:0] data;
        data = '0;
        data[16*k +: 16] = d;
        applyStimulus(NUM_REQ'(1) << k, data, ready);
        applyStimulus('0, data, ready);
    endtask

    task automatic waitRsp(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (rsp_data_log.size() < target && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        checkOutput(tag, 32'(rsp_data_log.size() >= target), 32'd1);
    endtask

    task automatic doReset(input int len);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        repeat (len) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin : stimulus
        int base;
        int gbase;
        int ebase;
        int n;

        // Reset: every output is zero even with all requests raised.
        req_valid_i = '1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready_o), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        checkOutput("reset_busy",      32'(busy_o),      32'h0);
        checkOutput("reset_err_cnt",   32'(err_cnt_o),   32'h0);
        checkOutput("reset_rsp_data",  rsp_data_o,       32'h0);
        req_valid_i = '0;
        rst_ni = 1'b1;

        // Single job from requester 0.
        base  = rsp_data_log.size();
        ebase = en_count;
        pulseReq(0, 16'h0041, 1'b1);
        waitRsp(base + 1, 30, "single_done");
        checkOutput("single_data",    rsp_data_log[base],       32'h0000_0042);
        checkOutput("single_id",      32'(rsp_id_log[base]),    32'h0);
        checkOutput("single_err",     32'(rsp_err_log[base]),   32'h0);
        checkOutput("single_din",     32'(en_din),              32'h0041);
        checkOutput("single_enables", 32'(en_count - ebase),    32'd1);
        checkOutput("single_latency", 32'(rsp_cyc - accept_cyc), 32'd6);

        // Round-robin with all requesters continuously valid from rr_ptr = 0.
        doReset(2);
        base  = rsp_data_log.size();
        gbase = grant_log.size();
        applyStimulus('1, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1'b1);
        n = 0;
        while (grant_log.size() < gbase + 5 && n < 60) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        req_valid_i = '0;
        checkOutput("rr_grants_seen", 32'(grant_log.size() >= gbase + 5), 32'd1);
        waitRsp(base + 5, 60, "rr_done");
        checkOutput("rr_grant0", 32'(grant_log[gbase + 0]), 32'd0);
        checkOutput("rr_grant1", 32'(grant_log[gbase + 1]), 32'd1);
        checkOutput("rr_grant2", 32'(grant_log[gbase + 2]), 32'd2);
        checkOutput("rr_grant3", 32'(grant_log[gbase + 3]), 32'd3);
        checkOutput("rr_grant4", 32'(grant_log[gbase + 4]), 32'd0);
        checkOutput("rr_rsp0", rsp_data_log[base + 0], 32'h11);
        checkOutput("rr_rsp1", rsp_data_log[base + 1], 32'h21);
        checkOutput("rr_rsp2", rsp_data_log[base + 2], 32'h31);
        checkOutput("rr_rsp3", rsp_data_log[base + 3], 32'h41);

        // Backpressure: response held for 10 cycles while requester 1 waits.
        base = rsp_data_log.size();
        pulseReq(0, 16'h0100, 1'b0);
        applyStimulus(4'b0010, {16'h0, 16'h0, 16'h0200, 16'h0}, 1'b0);
        n = 0;
        while (!rsp_valid_o && n < 30) begin
            @(posedge clk_i);
            n++;
        end
        checkOutput("bp_rsp_seen", 32'(rsp_valid_o), 32'd1);
        gbase = grant_log.size();
        ebase = en_count;
        repeat (10) @(posedge clk_i);
        #1;
        checkOutput("bp_valid_held", 32'(rsp_valid_o),        32'd1);
        checkOutput("bp_data_held",  rsp_data_o,               32'h101);
        checkOutput("bp_id_held",    32'(rsp_id_o),            32'd0);
        checkOutput("bp_no_grant",   32'(grant_log.size() - gbase), 32'd0);
        checkOutput("bp_no_enable",  32'(en_count - ebase),    32'd0);
        rsp_ready_i = 1'b1;
        n = 0;
        while (grant_log.size() == gbase && n < 10) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        req_valid_i = '0;
        checkOutput("bp_next_grant",   32'(grant_log[grant_log.size() - 1]), 32'd1);
        checkOutput("bp_grant_timing", 32'(accept_cyc - hs_cyc),           32'd1);
        waitRsp(base + 2, 30, "bp_done");
        checkOutput("bp_rsp1_data", rsp_data_log[base + 1], 32'h201);

        // Engine 16-bit wrap is passed through.
        base = rsp_data_log.size();
        pulseReq(2, 16'hFFFF, 1'b1);
        waitRsp(base + 1, 30, "wrap_done");
        checkOutput("wrap_data", rsp_data_log[base],     32'h0);
        checkOutput("wrap_err",  32'(rsp_err_log[base]), 32'd0);

        // Engine ERROR while waiting for DONE.
        eng_mode = 1;
        base = rsp_data_log.size();
        pulseReq(3, 16'h1234, 1'b1);
        waitRsp(base + 1, 30, "error_done");
        checkOutput("error_err",  32'(rsp_err_log[base]), 32'd1);
        checkOutput("error_data", rsp_data_log[base],     32'h0);
        checkOutput("error_id",   32'(rsp_id_log[base]),  32'd3);
        #10;
        checkOutput("error_cnt",  32'(err_cnt_o),         32'd1);

        // Watchdog timeout with the engine stuck BUSY.
        eng_mode = 2;
        base = rsp_data_log.size();
        pulseReq(0, 16'h0005, 1'b1);
        waitRsp(base + 1, 60, "timeout_done");
        checkOutput("timeout_err",     32'(rsp_err_log[base]),      32'd1);
        checkOutput("timeout_latency", 32'(rsp_cyc - accept_cyc),   32'(TIMEOUT_CYC + 2));
        #10;
        checkOutput("timeout_cnt",     32'(err_cnt_o),              32'd2);

        // Reset in the middle of WAIT_DONE drops the job.
        eng_mode = 0;
        base  = rsp_data_log.size();
        ebase = en_count;
        pulseReq(1, 16'h0077, 1'b1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_busy",      32'(busy_o),       32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid_o),  32'd0);
        checkOutput("midrst_enable",    32'(eng_enable_o), 32'd0);
        checkOutput("midrst_din",       32'(eng_din_o),    32'd0);
        checkOutput("midrst_err_cnt",   32'(err_cnt_o),    32'd0);
        checkOutput("midrst_rsp_err",   32'(rsp_err_o),    32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (25) @(posedge clk_i);
        #1;
        checkOutput("midrst_no_rsp",    32'(rsp_data_log.size() - base), 32'd0);
        checkOutput("midrst_one_enable", 32'(en_count - ebase),          32'd1);

        // Error counter saturation.
        eng_mode = 1;
        base = rsp_data_log.size();
        applyStimulus('1, {16'h4, 16'h3, 16'h2, 16'h1}, 1'b1);
        waitRsp(base + 260, 1500, "sat_done");
        req_valid_i = '0;
        n = 0;
        while (busy_o && n < 30) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        checkOutput("sat_idle", 32'(busy_o),    32'd0);
        checkOutput("sat_cnt",  32'(err_cnt_o), 32'd255);

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/custom_axi_ip_sched.md
# custom_axi_ip_sched

Round-robin job scheduler that shares one `custom_axi_ip` increment engine among `NUM_REQ` requesters. It sits between the register-side requesters and the engine's hardware interface. It arbitrates one job at a time, pulses the engine's enable for one cycle, and tracks the engine status sequence (IDLE→BUSY→DONE→IDLE). It captures the engine result and returns it, tagged with the requester ID, over a valid/ready response channel. It also detects engine ERROR and watchdog timeout.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYC`, 16, max cycles spent in WAIT_DONE+WAIT_RESULT before abort (≥8)
- `ID_W`, `$clog2(NUM_REQ)`, requester ID width (derived, not overridden)

Ports:
- `clk_i` in 1 — single clock
- `rst_ni` in 1 — reset, asynchronous, active-low
- `req_valid_i` in NUM_REQ — per-requester job request
- `req_data_i` in NUM_REQ*16 — per-requester operand; requester k occupies bits [16k+15:16k]
- `req_ready_o` out NUM_REQ — one-hot grant; a job transfers when `req_valid_i[k] & req_ready_o[k]`
- `rsp_valid_o` out 1 — response available
- `rsp_ready_i` in 1 — response consumer ready
- `rsp_id_o` out ID_W — index of requester that issued the job
- `rsp_data_o` out 32 — engine result (0 on error/timeout)
- `rsp_err_o` out 1 — 1 = engine ERROR or timeout
- `eng_din_o` out 16 — operand to engine `din`
- `eng_enable_o` out 1 — to engine `enable_in`; single-cycle pulse
- `eng_dout_i` in 32 — from engine `dout`
- `eng_status_i` in 2 — from engine `status_out`; IDLE=0, BUSY=1, DONE=2, ERROR=3
- `busy_o` out 1 — high in every state except IDLE
- `err_cnt_o` out 8 — saturating count of error/timeout responses

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, WAIT_RESULT, RESPOND. Only one job is outstanding at any time.
- IDLE:
  - `req_ready_o` is combinationally one-hot at the round-robin winner: the first asserted `req_valid_i` searching from `rr_ptr` upward with wrap.
  - `req_ready_o` is all zero when no request is valid, and all zero in every other state.
  - On transfer: latch operand and ID, set `rr_ptr` = winner+1 mod NUM_REQ, go to ISSUE.
- ISSUE:
  - `eng_enable_o`=1 and `eng_din_o`=latched operand, for exactly this cycle.
  - Clear the timeout counter and go to WAIT_DONE.
  - `eng_din_o` holds the latched operand in all other states.
- WAIT_DONE:
  - `eng_status_i`==DONE → WAIT_RESULT.
  - `eng_status_i`==ERROR → RESPOND with err=1, data=0.
  - IDLE/BUSY → stay.
- WAIT_RESULT: `eng_status_i`==IDLE → capture `eng_dout_i` into `rsp_data_o`, err=0, go to RESPOND. Otherwise stay.
- Timeout: the counter increments each cycle in WAIT_DONE/WAIT_RESULT. On reaching TIMEOUT_CYC → RESPOND with err=1, data=0. ERROR and timeout in the same cycle produce a single error response.
- RESPOND:
  - `rsp_valid_o`=1; `rsp_id_o`, `rsp_data_o` and `rsp_err_o` are held stable until `rsp_ready_i`=1.
  - On handshake → IDLE. `rsp_valid_o` is low the next cycle.
- `err_cnt_o` increments on each error response handshake and saturates at 255.
- Result data is passed through unmodified. The engine's 16-bit wrap (0xFFFF→0x0000) is not corrected.

## Timing
- Reset (async assert, sync-to-clock deassert handled upstream) returns all outputs to 0, FSM to IDLE and `rr_ptr` to 0.
- Reset mid-job drops the job; no response is produced.
- Accept at cycle a:
  - ISSUE/enable pulse at a+1.
  - Engine DONE seen at a+4; IDLE with valid `dout` at a+5.
  - `rsp_valid_o` first high at a+6, given a nominal engine.
- Back-to-back: response handshake at cycle r → IDLE at r+1, where a new grant may occur. Minimum 7 cycles per job.
- Requesters may drop `req_valid_i` without a grant; there is no ordering guarantee beyond round-robin.
- `eng_enable_o` is never high in two consecutive cycles and never high outside ISSUE.

## Test plan
- Single job: req0 valid, data 0x0041 → one enable pulse with `eng_din_o`=0x0041; `rsp_valid_o` at accept+6 with id=0, data=0x00000042, err=0.
- Round-robin: all 4 requesters valid continuously with data 0x10,0x20,0x30,0x40 → grants 0,1,2,3,0; responses 0x11,0x21,0x31,0x41 in that order.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles → response fields stable, no new grant, no enable pulse. Release → handshake, IDLE next cycle.
- Wrap and error: data 0xFFFF → rsp data 0x00000000, err=0. Force `eng_status_i`=3 in WAIT_DONE → err=1, data=0, `err_cnt_o`=1.
- Timeout and reset: stub engine stuck at BUSY → err response after TIMEOUT_CYC (16) cycles. Assert `rst_ni` low mid-WAIT_DONE → all outputs 0 immediately, no response after release.
